// File: rtl/spi_kval_loader_pkg.sv
// Shared constants for the kval loader: frame geometry, command codes and FSM encoding.
// Both the host-side model and the bench import this package, so they use the same codes as the RTL.
package spi_kval_loader_pkg;

    localparam int DATA_W = 40;
    localparam int CMD_W  = 8;

    localparam logic [CMD_W-1:0] CMD_WRITE = 8'hA5;
    localparam logic [CMD_W-1:0] CMD_READ  = 8'h5A;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 3'd0;
    localparam fsm_state_t ST_CMD    = 3'd1;
    localparam fsm_state_t ST_DATA   = 3'd2;
    localparam fsm_state_t ST_COMMIT = 3'd3;
    localparam fsm_state_t ST_ABORT  = 3'd4;

endpackage

// File: rtl/spi_kval_loader_if.sv
// SPI pin bundle between the host controller (master) and the kval loader (slave).
interface spi_kval_loader_if;

    logic sclkPort;
    logic csPort;
    logic mosiPort;
    logic misoPort;

    modport master (output sclkPort, output csPort, output mosiPort, input misoPort);
    modport slave  (input sclkPort, input csPort, input mosiPort, output misoPort);

endinterface

// File: rtl/spi_kval_loader_pin_sync.sv
// Brings the asynchronous SPI pins into CLK67MHZ and derives sclk rise/fall and cs fall pulses.
// sclk and mosi go through identical depths, so mosi is sampled aligned with the sclk edge it came with.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK67MHZ,
    input  logic resetPort,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_s,
    output logic cs_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_s;

    // NOTE: every flop uses <= so all stages sample the pre-edge values and the chain really is SYNC_STAGES deep.
    always_ff @(posedge CLK67MHZ or negedge resetPort) begin
        if (!resetPort) begin
            sclk_sr <= '0;
            cs_sr   <= '1;  // deselected, so a cs held low at release still produces a fall
            mosi_sr <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sclk_d  <= sclk_s;
            cs_d    <= cs_s;
        end
    end

    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;

endmodule

// File: rtl/spi_kval_loader.sv
// SPI mode-0 slave that loads the 40-bit tuning word and applies it to kval atomically, with read-back.
// Everything runs on CLK67MHZ; the SPI pins are oversampled through spi_pin_sync.
module spi_kval_loader
    import spi_kval_loader_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] KVAL_RESET = '0
) (
    input  logic              CLK67MHZ,
    input  logic              resetPort,
    spi_kval_loader_if.slave  spi,
    output logic [DATA_W-1:0] kval,
    output logic              kvalStrobe,
    output logic              frameErr,
    output logic [7:0]        errCount
);

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_s;
    logic              cs_fall;
    logic              mosi_s;

    fsm_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CMD_W-2:0]  cmd_sr;
    logic [CMD_W-1:0]  cmd_next;
    logic [DATA_W-1:0] shadow;
    logic              is_read;
    logic              miso_q;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .CLK67MHZ  (CLK67MHZ),
        .resetPort (resetPort),
        .sclk      (spi.sclkPort),
        .cs_n      (spi.csPort),
        .mosi      (spi.mosiPort),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_s      (cs_s),
        .cs_fall   (cs_fall),
        .mosi_s    (mosi_s)
    );

    assign cmd_next = {cmd_sr, mosi_s};

    always_ff @(posedge CLK67MHZ or negedge resetPort) begin
        if (!resetPort) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            shadow     <= '0;
            is_read    <= 1'b0;
            miso_q     <= 1'b0;
            kval       <= KVAL_RESET;
            kvalStrobe <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            kvalStrobe <= 1'b0;
            frameErr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        miso_q  <= 1'b0;
                        state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // A rise arriving with the cs rise is still counted before the deselect is judged.
                    if (sclk_rise) begin
                        cmd_sr <= cmd_next[CMD_W-2:0];
                        if (bit_cnt == CMD_LAST) begin
                            bit_cnt <= '0;
                            if (cmd_next == CMD_WRITE) begin
                                is_read <= 1'b0;
                                state   <= ST_DATA;
                            end else if (cmd_next == CMD_READ) begin
                                is_read <= 1'b1;
                                shadow  <= kval;
                                state   <= ST_DATA;
                            end else begin
                                frameErr <= 1'b1;
                                state    <= ST_ABORT;
                            end
                        end else if (cs_s) begin
                            frameErr <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (cs_s) begin
                        frameErr <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        if (!is_read) begin
                            shadow <= {shadow[DATA_W-2:0], mosi_s};
                        end
                        if (bit_cnt == DATA_LAST) begin
                            state <= ST_COMMIT;
                        end else if (cs_s) begin
                            frameErr <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (cs_s) begin
                        frameErr <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (sclk_fall && is_read) begin
                        miso_q <= shadow[DATA_W-1];
                        shadow <= {shadow[DATA_W-2:0], 1'b0};
                    end
                end
                ST_COMMIT: begin
                    if (!is_read) begin
                        kval       <= shadow;
                        kvalStrobe <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                ST_ABORT: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK67MHZ or negedge resetPort) begin
        if (!resetPort) begin
            errCount <= 8'd0;
        end else if (frameErr && errCount != 8'hFF) begin
            errCount <= errCount + 8'd1;
        end
    end

    assign spi.misoPort = miso_q & (state == ST_DATA) & is_read & ~cs_s;

endmodule

// File: tb/tb_spi_kval_loader.sv
// Directed bench for spi_kval_loader: write, read-back, bad command, truncation, reset, saturation, edge timing.
module tb_spi_kval_loader;
    import spi_kval_loader_pkg::*;

    logic              CLK67MHZ = 1'b0;
    logic              resetPort;
    logic [DATA_W-1:0] kval;
    logic              kvalStrobe;
    logic              frameErr;
    logic [7:0]        errCount;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int ferr_cnt = 0;

    spi_kval_loader_if bus ();

    spi_kval_loader dut (
        .CLK67MHZ   (CLK67MHZ),
        .resetPort  (resetPort),
        .spi        (bus),
        .kval       (kval),
        .kvalStrobe (kvalStrobe),
        .frameErr   (frameErr),
        .errCount   (errCount)
    );

    always #7 CLK67MHZ = ~CLK67MHZ;

    always @(negedge CLK67MHZ) begin
        if (resetPort === 1'b1) begin
            if (kvalStrobe === 1'b1) strobe_cnt++;
            if (frameErr === 1'b1) ferr_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic start_frame();
        bus.sclkPort = 1'b0;
        bus.csPort   = 1'b0;
        repeat (6) @(negedge CLK67MHZ);
    endtask

    // Leaves sclk high right after the n-th rise so the caller can time what follows.
    task automatic shift_bits(input logic [47:0] word, input int n, output logic [47:0] miso_word);
        miso_word = '0;
        for (int i = 0; i < n; i++) begin
            bus.sclkPort = 1'b0;
            bus.mosiPort = word[47-i];
            repeat (5) @(negedge CLK67MHZ);
            miso_word[47-i] = bus.misoPort;
            bus.sclkPort = 1'b1;
            if (i != n - 1) repeat (5) @(negedge CLK67MHZ);
        end
    endtask

    task automatic end_frame();
        repeat (5) @(negedge CLK67MHZ);
        bus.sclkPort = 1'b0;
        repeat (3) @(negedge CLK67MHZ);
        bus.csPort = 1'b1;
        repeat (8) @(negedge CLK67MHZ);
    endtask

    task automatic write_frame(input logic [DATA_W-1:0] value);
        logic [47:0] mw;
        start_frame();
        shift_bits({CMD_WRITE, value}, 48, mw);
        end_frame();
    endtask

    task automatic bad_short_frame();
        logic [47:0] mw;
        start_frame();
        shift_bits({8'h3C, 40'h0}, 8, mw);
        end_frame();
    endtask

    task automatic test_reset();
        checks++; if (kval !== 40'h0) begin errors++; $display("FAIL reset_kval got %h want %h", kval, 40'h0); end
        checks++; if (errCount !== 8'h00) begin errors++; $display("FAIL reset_errcount got %h want 00", errCount); end
        checks++; if (kvalStrobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", kvalStrobe); end
        checks++; if (frameErr !== 1'b0) begin errors++; $display("FAIL reset_frameerr got %b want 0", frameErr); end
        checks++; if (bus.misoPort !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", bus.misoPort); end
    endtask

    task automatic test_write();
        logic [47:0] mw;
        int s0;
        s0 = strobe_cnt;
        start_frame();
        shift_bits({8'hA5, 40'h00_1234_5678}, 48, mw);
        repeat (3) @(posedge CLK67MHZ);
        #1;
        checks++; if (kval !== 40'h0) begin errors++; $display("FAIL write_kval_early got %h want %h", kval, 40'h0); end
        @(posedge CLK67MHZ);
        #1;
        checks++; if (kval !== 40'h00_1234_5678) begin errors++; $display("FAIL write_kval_latency4 got %h want %h", kval, 40'h0012345678); end
        checks++; if (kvalStrobe !== 1'b1) begin errors++; $display("FAIL write_strobe_cycle got %b want 1", kvalStrobe); end
        end_frame();
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL write_strobe_count got %0d want 1", strobe_cnt - s0); end
        checks++; if (errCount !== 8'h00) begin errors++; $display("FAIL write_errcount got %h want 00", errCount); end
    endtask

    task automatic test_read();
        logic [47:0] mw;
        int s0;
        int f0;
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        start_frame();
        shift_bits({8'h5A, 40'hAA_5555_AAAA}, 48, mw);
        end_frame();
        checks++; if (mw[39:0] !== 40'h00_1234_5678) begin errors++; $display("FAIL read_data got %h want %h", mw[39:0], 40'h0012345678); end
        checks++; if (mw[47:40] !== 8'h00) begin errors++; $display("FAIL read_cmd_phase_miso got %h want 00", mw[47:40]); end
        checks++; if (kval !== 40'h00_1234_5678) begin errors++; $display("FAIL read_kval got %h want %h", kval, 40'h0012345678); end
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL read_strobe got %0d want 0", strobe_cnt - s0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL read_frameerr got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_bad_cmd();
        logic [47:0] mw;
        int s0;
        int f0;
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        start_frame();
        shift_bits({8'h3C, 40'hFF_FFFF_FFFF}, 48, mw);
        end_frame();
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL badcmd_frameerr got %0d want 1", ferr_cnt - f0); end
        checks++; if (errCount !== 8'h01) begin errors++; $display("FAIL badcmd_errcount got %h want 01", errCount); end
        checks++; if (kval !== 40'h00_1234_5678) begin errors++; $display("FAIL badcmd_kval got %h want %h", kval, 40'h0012345678); end
        checks++; if (mw !== 48'h0) begin errors++; $display("FAIL badcmd_miso got %h want 0", mw); end
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL badcmd_strobe got %0d want 0", strobe_cnt - s0); end
    endtask

    task automatic test_truncated();
        logic [47:0] mw;
        int s0;
        int f0;
        s0 = strobe_cnt;
        f0 = ferr_cnt;
        start_frame();
        shift_bits({8'hA5, 40'hAB_CDE0_0000}, 28, mw);
        end_frame();
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL trunc_frameerr got %0d want 1", ferr_cnt - f0); end
        checks++; if (errCount !== 8'h02) begin errors++; $display("FAIL trunc_errcount got %h want 02", errCount); end
        checks++; if (kval !== 40'h00_1234_5678) begin errors++; $display("FAIL trunc_kval_hold got %h want %h", kval, 40'h0012345678); end
        write_frame(40'hFF_FFFF_FFFF);
        checks++; if (kval !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL trunc_next_kval got %h want %h", kval, 40'hFFFFFFFFFF); end
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL trunc_strobe got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_cs_with_last_rise();
        logic [47:0] mw;
        int f0;
        int s0;
        f0 = ferr_cnt;
        s0 = strobe_cnt;
        start_frame();
        shift_bits({8'hA5, 40'h00_00C0_FFEE}, 48, mw);
        bus.csPort = 1'b1;
        repeat (10) @(negedge CLK67MHZ);
        bus.sclkPort = 1'b0;
        repeat (5) @(negedge CLK67MHZ);
        checks++; if (kval !== 40'h00_00C0_FFEE) begin errors++; $display("FAIL csedge_kval got %h want %h", kval, 40'h0000C0FFEE); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL csedge_frameerr got %0d want 0", ferr_cnt - f0); end
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL csedge_strobe got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_reset_midframe();
        logic [47:0] mw;
        int s0;
        start_frame();
        shift_bits({8'hA5, 40'h12_3456_789A}, 30, mw);
        resetPort = 1'b0;
        #2;
        checks++; if (kval !== 40'h0) begin errors++; $display("FAIL rstmid_kval got %h want 0", kval); end
        checks++; if (errCount !== 8'h00) begin errors++; $display("FAIL rstmid_errcount got %h want 00", errCount); end
        checks++; if (bus.misoPort !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b want 0", bus.misoPort); end
        bus.sclkPort = 1'b0;
        bus.csPort   = 1'b1;
        bus.mosiPort = 1'b0;
        repeat (3) @(negedge CLK67MHZ);
        resetPort = 1'b1;
        repeat (4) @(negedge CLK67MHZ);
        write_frame(40'h1);
        checks++; if (kval !== 40'h1) begin errors++; $display("FAIL rstmid_reload got %h want 1", kval); end
        checks++; if (errCount !== 8'h00) begin errors++; $display("FAIL rstmid_no_err got %h want 00", errCount); end
        s0 = strobe_cnt;
        write_frame(40'h1);
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL samevalue_strobe got %0d want 1", strobe_cnt - s0); end
        checks++; if (kval !== 40'h1) begin errors++; $display("FAIL samevalue_kval got %h want 1", kval); end
    endtask

    task automatic test_saturation();
        int f0;
        f0 = ferr_cnt;
        for (int i = 0; i < 254; i++) bad_short_frame();
        checks++; if (errCount !== 8'hFE) begin errors++; $display("FAIL sat_errcount_254 got %h want FE", errCount); end
        for (int i = 0; i < 6; i++) bad_short_frame();
        checks++; if (errCount !== 8'hFF) begin errors++; $display("FAIL sat_errcount_260 got %h want FF", errCount); end
        checks++; if (ferr_cnt - f0 !== 260) begin errors++; $display("FAIL sat_pulses got %0d want 260", ferr_cnt - f0); end
        checks++; if (kval !== 40'h1) begin errors++; $display("FAIL sat_kval got %h want 1", kval); end
    endtask

    initial begin
        resetPort    = 1'b0;
        bus.sclkPort = 1'b0;
        bus.csPort   = 1'b1;
        bus.mosiPort = 1'b0;
        repeat (4) @(negedge CLK67MHZ);
        test_reset();
        resetPort = 1'b1;
        repeat (4) @(negedge CLK67MHZ);
        test_write();
        test_read();
        test_bad_cmd();
        test_truncated();
        test_cs_with_last_rise();
        test_reset_midframe();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
